// File: rtl/banked_register_file.sv
// banked_register_file
// Two-bank (integer / float) register file with NUM_RD registered read
// ports and one write port. After reset a clear sequencer zeroes both banks,
// one address per cycle, before ready is raised.
// Integer register 0 reads as zero and ignores writes; float register 0 is
// an ordinary register.
//
// Build option: define REGFILE_BYPASS_EN to forward a same-edge write to any
// read port addressing the same bank/register. Without it, that read returns
// the value held before the write.
//
// state | meaning
// ------+-----------------------------------------------------------------
// CLEAR | zeroing int/flt entry clearIdx each cycle; writes dropped, reads 0
// RUN   | normal operation; ready high

module banked_register_file #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int NUM_RD = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  input  logic [NUM_RD-1:0]          rd_float,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  input  logic                       wr_en,
  input  logic                       wr_float,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  output logic                       ready
);

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } fileState_e;

  fileState_e        state;
  fileState_e        stateNext;
  logic [ADDR_W-1:0] clearIdx;
  logic [ADDR_W-1:0] clearIdxNext;
  logic              lastClear;
  logic              readyReg;

  logic [DATA_W-1:0] intBank [DEPTH];
  logic [DATA_W-1:0] fltBank [DEPTH];

  logic              running;
  logic              intWr;
  logic              fltWr;

  logic [ADDR_W-1:0] portAddr [NUM_RD];
  logic              portFlt  [NUM_RD];
  logic [DATA_W-1:0] rdNext   [NUM_RD];
  logic [DATA_W-1:0] rdReg    [NUM_RD];

  assign running = (state == RUN);

  // Integer writes to address 0 are discarded so that entry never changes.
  assign intWr = running && wr_en && !wr_float && (wr_addr != '0);
  assign fltWr = running && wr_en &&  wr_float;

  // State register and clear index; reset restarts the clear from index 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= CLEAR;
      clearIdx <= '0;
    end else begin
      state    <= stateNext;
      clearIdx <= clearIdxNext;
    end
  end

  // Next-state logic: walk clearIdx through every address, then go to RUN.
  always_comb begin
    stateNext    = state;
    clearIdxNext = clearIdx;
    lastClear    = 1'b0;
    case (state)
      CLEAR: begin
        lastClear    = (clearIdx == ADDR_W'(DEPTH - 1));
        clearIdxNext = clearIdx + 1'b1;
        if (lastClear) begin
          stateNext = RUN;
        end
      end
      RUN: begin
        stateNext = RUN;
      end
      default: begin
        stateNext = CLEAR;
      end
    endcase
  end

  // ready rises on the same edge that writes the last clear address.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      readyReg <= 1'b0;
    end else if (lastClear) begin
      readyReg <= 1'b1;
    end
  end

  assign ready = readyReg;

  // Bank storage: clear writes in CLEAR, port writes in RUN, nothing in reset.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (!running) begin
        intBank[clearIdx] <= '0;
        fltBank[clearIdx] <= '0;
      end else begin
        if (intWr) begin
          intBank[wr_addr] <= wr_data;
        end
        if (fltWr) begin
          fltBank[wr_addr] <= wr_data;
        end
      end
    end
  end

  // Unpack per-port address and bank select.
  always_comb begin
    for (int k = 0; k < NUM_RD; k++) begin
      portAddr[k] = rd_addr[k*ADDR_W +: ADDR_W];
      portFlt[k]  = rd_float[k];
    end
  end

  // Per-port read value, with optional same-edge forwarding from the write port.
  always_comb begin
    for (int k = 0; k < NUM_RD; k++) begin
      rdNext[k] = '0;
      if (portFlt[k]) begin
        rdNext[k] = fltBank[portAddr[k]];
      end else if (portAddr[k] != '0) begin
        rdNext[k] = intBank[portAddr[k]];
      end
`ifdef REGFILE_BYPASS_EN
      // intWr/fltWr already exclude CLEAR and integer register 0.
      if ((portFlt[k] ? fltWr : intWr) && (portAddr[k] == wr_addr)) begin
        rdNext[k] = wr_data;
      end
`endif
    end
  end

  // Read data registers; held at zero until the clear has finished.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_RD; k++) begin
      if (!rst_n || !running) begin
        rdReg[k] <= '0;
      end else begin
        rdReg[k] <= rdNext[k];
      end
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : gRdOut
    assign rd_data[g*DATA_W +: DATA_W] = rdReg[g];
  end

endmodule

// File: tb/tb_banked_register_file.sv
// Directed bench for banked_register_file with a behavioural reference model.
// Follows REGFILE_BYPASS_EN the same way the design does.

module tb_banked_register_file;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_RD = 2;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD-1:0]        rd_float;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic                     wr_en;
  logic                     wr_float;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     ready;

  int vectors = 0;
  int miscompares = 0;

  banked_register_file #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_float(rd_float),
    .rd_data(rd_data), .wr_en(wr_en), .wr_float(wr_float),
    .wr_addr(wr_addr), .wr_data(wr_data), .ready(ready)
  );

  always #5 clk = ~clk;

  // Reference model: register contents as plain arrays; the file is known
  // to be all-zero once DEPTH clean edges have followed a reset.
  logic [DATA_W-1:0] intM [DEPTH];
  logic [DATA_W-1:0] fltM [DEPTH];
  logic [DATA_W-1:0] expRd [NUM_RD];
  logic              expReady;
  bit                modelValid = 1'b0;
  int                sinceRelease = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      modelValid   = 1'b1;
      sinceRelease = 0;
      expReady     = 1'b0;
      for (int k = 0; k < NUM_RD; k++) expRd[k] = '0;
    end else if (modelValid) begin
      sinceRelease++;
      if (sinceRelease <= DEPTH) begin
        for (int k = 0; k < NUM_RD; k++) expRd[k] = '0;
        expReady = 1'b0;
        if (sinceRelease == DEPTH) begin
          for (int a = 0; a < DEPTH; a++) begin
            intM[a] = '0;
            fltM[a] = '0;
          end
          expReady = 1'b1;
        end
      end else begin
        for (int k = 0; k < NUM_RD; k++) begin
          int a;
          bit f;
          logic [DATA_W-1:0] v;
          a = int'(rd_addr[k*ADDR_W +: ADDR_W]);
          f = rd_float[k];
          if (f) v = fltM[a];
          else if (a == 0) v = '0;
          else v = intM[a];
`ifdef REGFILE_BYPASS_EN
          if (wr_en && (f == wr_float) && (a == int'(wr_addr)) && (f || a != 0))
            v = wr_data;
`endif
          expRd[k] = v;
        end
        if (wr_en) begin
          if (wr_float) fltM[wr_addr] = wr_data;
          else if (wr_addr != '0) intM[wr_addr] = wr_data;
        end
      end
    end
  end

  function automatic logic [DATA_W-1:0] portData(input int k);
    return rd_data[k*DATA_W +: DATA_W];
  endfunction

  // Cycle-by-cycle comparison against the model.
  always @(posedge clk) begin
    #1;
    if (modelValid) begin
      vectors++;
      if (ready !== expReady) begin
        miscompares++;
        $display("FAIL model_ready t=%0t: got %b expected %b", $time, ready, expReady);
      end
      for (int k = 0; k < NUM_RD; k++) begin
        vectors++;
        if (portData(k) !== expRd[k]) begin
          miscompares++;
          $display("FAIL model_rd%0d t=%0t: got %h expected %h", k, $time, portData(k), expRd[k]);
        end
      end
    end
  end

  task automatic checkLit(input string name, input logic [DATA_W-1:0] act,
                          input logic [DATA_W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setRead(input int k, input bit flt, input int a);
    rd_addr[k*ADDR_W +: ADDR_W] = ADDR_W'(a);
    rd_float[k] = flt;
  endtask

  task automatic setWrite(input bit en, input bit flt, input int a,
                          input logic [DATA_W-1:0] d);
    wr_en    = en;
    wr_float = flt;
    wr_addr  = ADDR_W'(a);
    wr_data  = d;
  endtask

  // Release reset and count edges until ready; optionally inject a write
  // at clear edge dropAt and a one-cycle reset at clear edge resetAt.
  task automatic clearPhase(input int dropAt, input int resetAt, output int edges);
    edges = 0;
    for (int c = 1; c <= 4 * DEPTH; c++) begin
      setWrite(c == dropAt, 1'b0, 3, 32'h0000_00AA);
      rst_n = (c != resetAt);
      step();
      edges = (c == resetAt) ? 0 : edges + 1;
      if (ready === 1'b1) break;
    end
    setWrite(1'b0, 1'b0, 0, '0);
    rst_n = 1'b1;
  endtask

  task automatic readAllZero(input string tag);
    for (int a = 0; a < DEPTH; a++) begin
      setRead(0, 1'b0, a);
      setRead(1, 1'b1, a);
      step();
      checkLit({tag, "_int"}, portData(0), '0);
      checkLit({tag, "_flt"}, portData(1), '0);
    end
  endtask

  initial begin
    int edges;
    logic [DATA_W-1:0] hazardExp;

    rst_n = 1'b0;
    rd_addr = '0;
    rd_float = '0;
    setWrite(1'b0, 1'b0, 0, '0);
    repeat (3) step();
    checkLit("reset_ready", DATA_W'(ready), '0);
    checkLit("reset_rd0", portData(0), '0);
    checkLit("reset_rd1", portData(1), '0);

    // Clear with a write attempted at clear edge 10 (int r3 = 0xAA).
    clearPhase(10, 0, edges);
    checkLit("clear_edges", DATA_W'(edges), DATA_W'(DEPTH));
    checkLit("clear_ready", DATA_W'(ready), 32'd1);
    readAllZero("after_clear");

    // Bank isolation.
    setWrite(1'b1, 1'b0, 5, 32'h1234_5678);
    step();
    setWrite(1'b1, 1'b1, 5, 32'hDEAD_BEEF);
    step();
    setWrite(1'b0, 1'b0, 0, '0);
    setRead(0, 1'b0, 5);
    setRead(1, 1'b1, 5);
    step();
    checkLit("iso_int_r5", portData(0), 32'h1234_5678);
    checkLit("iso_flt_f5", portData(1), 32'hDEAD_BEEF);
    setRead(0, 1'b1, 5);
    step();
    checkLit("same_reg_p0", portData(0), 32'hDEAD_BEEF);
    checkLit("same_reg_p1", portData(1), 32'hDEAD_BEEF);

    // Zero register, including a same-edge read of int r0 while it is written.
    setWrite(1'b1, 1'b0, 0, 32'hFFFF_FFFF);
    setRead(0, 1'b0, 0);
    step();
    checkLit("r0_write_read", portData(0), '0);
    setWrite(1'b1, 1'b1, 0, 32'hFFFF_FFFF);
    step();
    setWrite(1'b0, 1'b0, 0, '0);
    setRead(0, 1'b0, 0);
    setRead(1, 1'b1, 0);
    step();
    checkLit("zero_int_r0", portData(0), '0);
    checkLit("zero_flt_f0", portData(1), 32'hFFFF_FFFF);

    // Same-cycle write/read hazard on int r7.
    setWrite(1'b1, 1'b0, 7, 32'h11);
    step();
    setWrite(1'b1, 1'b0, 7, 32'h22);
    setRead(0, 1'b0, 7);
    setRead(1, 1'b1, 7);
    step();
`ifdef REGFILE_BYPASS_EN
    hazardExp = 32'h22;
`else
    hazardExp = 32'h11;
`endif
    checkLit("hazard_same_edge", portData(0), hazardExp);
    checkLit("hazard_other_bank", portData(1), '0);
    setWrite(1'b0, 1'b0, 0, '0);
    step();
    checkLit("hazard_next", portData(0), 32'h22);

    // Mid-clear reset: dirty a register, full reset, then reset again at clear edge 20.
    setWrite(1'b1, 1'b1, 9, 32'h5A5A_5A5A);
    step();
    setWrite(1'b0, 1'b0, 0, '0);
    rst_n = 1'b0;
    repeat (2) step();
    checkLit("rst2_ready", DATA_W'(ready), '0);
    clearPhase(0, 20, edges);
    checkLit("midclear_edges", DATA_W'(edges), DATA_W'(DEPTH));
    checkLit("midclear_ready", DATA_W'(ready), 32'd1);
    readAllZero("after_midclear");

    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/banked_register_file.md
# banked_register_file

Parametrised two-bank (integer/float) register file for the modified-MIPS datapath, replacing the fixed 32x32 single-read-pair file. Provides NUM_RD independent read ports, each selecting its own bank, plus one write port. Read data is registered on the rising edge. A post-reset clear sequencer zeroes both banks before the pipeline is released. Sits between decode (read addresses) and writeback (write port).

## Interface
- DATA_W, 32, register width in bits
- DEPTH, 32, registers per bank (power of two, >= 2)
- ADDR_W, $clog2(DEPTH), register address width
- NUM_RD, 2, number of read ports (1..4)
- clk  input  1  clock; all logic on rising edge
- rst_n  input  1  reset, synchronous, active-low
- rd_addr  input  NUM_RD*ADDR_W  read addresses; port k at [k*ADDR_W +: ADDR_W]
- rd_float  input  NUM_RD  bank select per read port (1 = float, 0 = integer)
- rd_data  output  NUM_RD*DATA_W  registered read data; port k at [k*DATA_W +: DATA_W]
- wr_en  input  1  write strobe
- wr_float  input  1  write bank select (1 = float, 0 = integer)
- wr_addr  input  ADDR_W  write address
- wr_data  input  DATA_W  write data
- ready  output  1  high when the file accepts writes and returns valid reads

## Operation
- Two arrays, int_bank and flt_bank, DEPTH x DATA_W each.
- Integer register 0 is hardwired zero: writes to it are discarded, reads return 0. Float register 0 is an ordinary register.
- FSM states: CLEAR, RUN.
  - rst_n low at a clock edge: state <= CLEAR, clear index <= 0, ready <= 0, all rd_data <= 0.
  - CLEAR: each cycle writes 0 to int_bank[idx] and flt_bank[idx], idx increments; after idx = DEPTH-1 is written, state <= RUN, ready <= 1.
  - RUN: stays until rst_n low.
- In CLEAR: wr_en ignored (write dropped, not queued); rd_data held at 0.
- In RUN, on a rising edge with wr_en = 1: selected bank entry wr_addr <= wr_data (except integer entry 0).
- In RUN, each read port k independently: rd_data[k] <= selected bank[rd_addr[k]], or 0 for integer address 0.
- Multiple read ports may address the same register; all return the same value.
- Reset asserted mid-operation (including mid-CLEAR): clear restarts from index 0; no partial write occurs in the reset cycle.

## Timing
- Read latency: 1 cycle (address at edge N, data valid after edge N).
- Write latency: 1 cycle; stored value visible to reads sampled at the next edge.
- Same-cycle write and read of the same bank/address: governed by REGFILE_BYPASS_EN (see Configuration).
- Clear duration: DEPTH cycles after the first edge with rst_n high; ready rises after edge DEPTH (counting from 1).
- Reset values: ready = 0, rd_data = 0 (all ports), state = CLEAR, idx = 0.
- rd_data holds its value between edges; no combinational path from inputs to rd_data.

## Configuration
- REGFILE_BYPASS_EN defined: in RUN, if wr_en = 1 and rd_float[k] == wr_float and rd_addr[k] == wr_addr (excluding integer address 0), rd_data[k] <= wr_data at the same edge (write-before-read forwarding).
- REGFILE_BYPASS_EN not defined: the read in that cycle returns the pre-write value; the new value appears on the following read.
- Forwarding is never applied in CLEAR or from integer register 0.

## Test plan
- Reset/clear: hold rst_n low 3 cycles, release -> ready = 0 for exactly 32 edges, ready = 1 after edge 32; all 64 registers read 0.
- Bank isolation: write int r5 = 0x1234_5678, flt f5 = 0xDEAD_BEEF; read port0 int r5, port1 flt f5 -> 0x1234_5678 and 0xDEAD_BEEF one cycle later.
- Zero register: write int r0 = 0xFFFF_FFFF and flt f0 = 0xFFFF_FFFF -> int r0 reads 0, flt f0 reads 0xFFFF_FFFF.
- Same-cycle hazard: r7 = 0x11, then write r7 = 0x22 while port0 reads r7 -> 0x22 with REGFILE_BYPASS_EN, 0x11 without; next read 0x22 in both builds.
- Write during CLEAR: wr_en = 1 int r3 = 0xAA at clear cycle 10 -> dropped; r3 reads 0 after ready.
- Mid-clear reset: assert rst_n low at clear cycle 20 for 1 cycle -> ready stays 0 for a further 32 edges, then rises; registers read 0.
